// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory unit: FSM states, access size codes,
// the position of the sign-extend flag in sign_mask, and a size-code check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;

  // sign_mask[SIGN_BIT] selects sign extension on loads
  localparam int SIGN_BIT = 3;

  function automatic logic size_valid(input logic [2:0] sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering shared by the RAM and LED paths.
// Load side: shifts the addressed lanes down and sign/zero-extends them.
// Store side: shifts store data up into its lanes, produces byte enables and
// the word with the addressed lanes replaced. An invalid size yields no enables.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  size,
  input  logic        sext,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merged,
  output logic [3:0]  be
);

  logic [31:0] down;
  logic [31:0] up;

  // Extract/extend the load value and build the lane-merged store word
  always_comb begin
    down     = word >> {lane, 3'b000};
    up       = store_data << {lane, 3'b000};
    be       = 4'b0000;
    load_val = '0;
    case (size)
      SZ_BYTE: begin
        be       = 4'b0001 << lane;
        load_val = {{24{sext & down[7]}}, down[7:0]};
      end
      SZ_HALF: begin
        be       = 4'b0011 << {lane[1], 1'b0};
        load_val = {{16{sext & down[15]}}, down[15:0]};
      end
      SZ_WORD: begin
        be       = 4'b1111;
        load_val = down;
      end
      default: ;
    endcase
    merged = word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = up[8*k +: 8];
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory unit for the RV32I MEM stage: word-organised single-port RAM,
// byte/half/word loads and stores with sign/zero extension, a memory-mapped
// LED register, access-fault detection and a registered clk_stall.
// Optional build macro DMEM_BYTE_ENABLE_STORE_EN: the RAM uses byte-lane write
// enables and stores bypass the read of the old word (IDLE -> COMMIT directly).
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter logic [31:0] LED_ADDR    = 32'h2000,
  parameter int          LED_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      write_data,
  input  logic             memwrite,
  input  logic             memread,
  input  logic [3:0]       sign_mask,
  output logic [31:0]      read_data,
  output logic             clk_stall,
  output logic [LED_W-1:0] led,
  output logic             err
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  state_t      state;
  logic        store_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;
  logic        sext_q;
  logic [31:0] word_buf;

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_ram;
  logic             is_led;
  logic             misaligned;
  logic             fault;
  logic [31:0]      led_ext;
  logic [31:0]      src_word;
  logic [31:0]      load_val;
  logic [31:0]      merged;
  logic [3:0]       be;
  logic             ram_re;
  logic             ram_we;

  // Capture the request every IDLE cycle; held stable while the access is in flight
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      addr_q  <= addr;
      wdata_q <= write_data;
      size_q  <= sign_mask[2:0];
      sext_q  <= sign_mask[SIGN_BIT];
    end
  end

  // Decode the captured address and classify the access
  always_comb begin
    offset     = addr_q - BASE_ADDR;
    in_ram     = (addr_q >= BASE_ADDR) && (offset < RAM_BYTES);
    is_led     = (addr_q == LED_ADDR);
    misaligned = ((size_q == SZ_HALF) && addr_q[0]) ||
                 ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
    fault      = misaligned || !(in_ram || is_led) || !size_valid(size_q);
    idx        = offset[IDX_W+1:2];
    led_ext    = 32'(led);
    src_word   = is_led ? led_ext : word_buf;
    ram_re     = (state == LOOKUP);
    ram_we     = (state == COMMIT) && !fault && !is_led && (be != 4'b0000);
  end

  dmem_lane_align u_align (
    .word       (src_word),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .sext       (sext_q),
    .store_data (wdata_q),
    .load_val   (load_val),
    .merged     (merged),
    .be         (be)
  );

  // Single-port RAM: one read (LOOKUP) or one write (COMMIT) per cycle
  always_ff @(posedge clk) begin
`ifdef DMEM_BYTE_ENABLE_STORE_EN
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) ram[idx][8*k +: 8] <= merged[8*k +: 8];
      end
    end
`else
    if (ram_we) ram[idx] <= merged;
`endif
    if (ram_re) word_buf <= ram[idx];
  end

  // Access sequencer with registered stall, load result, LED and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      store_q   <= 1'b0;
      clk_stall <= 1'b0;
      read_data <= '0;
      led       <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          // a simultaneous read and write is handled as a store
          store_q <= memwrite;
          if (memread || memwrite) begin
            clk_stall <= 1'b1;
`ifdef DMEM_BYTE_ENABLE_STORE_EN
            state <= memwrite ? COMMIT : LOOKUP;
`else
            state <= LOOKUP;
`endif
          end
        end
        LOOKUP: begin
          state <= store_q ? COMMIT : RESP;
        end
        RESP: begin
          read_data <= fault ? '0 : load_val;
          err       <= fault;
          clk_stall <= 1'b0;
          state     <= IDLE;
        end
        COMMIT: begin
          if (!fault && is_led) led <= merged[LED_W-1:0];
          err       <= fault;
          clk_stall <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: a table of directed vectors, reset
// corner sequences, and randomized accesses against a byte-level memory model.
module tb_data_mem_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic [7:0]  led;
  logic        err;

  int checks;
  int errors;

`ifdef DMEM_BYTE_ENABLE_STORE_EN
  localparam int STORE_STALL = 1;
`else
  localparam int STORE_STALL = 2;
`endif
  localparam int LOAD_STALL = 2;

  data_mem_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .clk_stall  (clk_stall),
    .led        (led),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  sm;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t tbl[21];

  // Reference model state
  logic [7:0]  mref [0:63];
  logic [7:0]  m_led;
  logic [31:0] m_rd;
  logic        m_err;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] sm,
                              input logic [31:0] exp_rd, input logic exp_err,
                              input logic [7:0] exp_led);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.d = d; v.sm = sm;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_led = exp_led;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One complete access; request presented on a falling edge, results sampled 1ns after rising edges
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sm,
                        output logic [31:0] rdata, output logic e, output int sc);
    int guard;
    @(negedge clk);
    addr = a; write_data = d; memwrite = wr; memread = rd; sign_mask = sm;
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
    sc = 0; e = 1'b0; guard = 0;
    while (clk_stall && guard < 10) begin
      sc++;
      @(posedge clk); #1;
      if (err) e = 1'b1;
      guard++;
    end
    if (guard >= 10) begin
      checks++; errors++;
      $display("FAIL stall_timeout actual=stuck required=release");
    end
    rdata = read_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Byte-granular model of the architectural effect of one access
  task automatic model(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sm);
    int n;
    logic f, inr, isl;
    logic [31:0] v, lw;
    case (sm[2:0])
      3'b001:  n = 1;
      3'b011:  n = 2;
      3'b111:  n = 4;
      default: n = 0;
    endcase
    inr = (a >= 32'h1000) && (a < 32'h1000 + 32'd4096);
    isl = (a == 32'h2000);
    f = (n == 0) || !(inr || isl);
    if (n != 0 && (a % n) != 0) f = 1'b1;
    m_err = f;
    if (wr) begin
      if (!f) begin
        if (isl) begin
          lw = 32'(m_led);
          for (int i = 0; i < n; i++) lw[8*i +: 8] = d[8*i +: 8];
          m_led = lw[7:0];
        end else begin
          for (int i = 0; i < n; i++) mref[int'(a - 32'h1000) + i] = d[8*i +: 8];
        end
      end
    end else if (rd) begin
      if (f) m_rd = '0;
      else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v[8*i +: 8] = isl ? ((i == 0) ? m_led : 8'h00) : mref[int'(a - 32'h1000) + i];
        if (sm[3] && v[8*n-1])
          for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        m_rd = v;
      end
    end
  endtask

  initial begin
    logic [31:0] rdv;
    logic        ev;
    int          sc;
    logic        wr, rd;
    logic [31:0] a, d;
    logic [3:0]  sm;
    logic [2:0]  good_sz [3];
    logic [2:0]  bad_sz  [5];
    logic [31:0] bad_a   [3];

    checks = 0; errors = 0;
    rst_n = 1'b0; addr = '0; write_data = '0; memwrite = 1'b0; memread = 1'b0; sign_mask = '0;
    good_sz[0] = 3'b001; good_sz[1] = 3'b011; good_sz[2] = 3'b111;
    bad_sz[0] = 3'b000; bad_sz[1] = 3'b010; bad_sz[2] = 3'b100; bad_sz[3] = 3'b101; bad_sz[4] = 3'b110;
    bad_a[0] = 32'h0000_0FFC; bad_a[1] = 32'h0000_2000 + 32'd4; bad_a[2] = 32'h0000_1000 + 32'd4096;

    tbl[0]  = mk(1, 0, 32'h1000, 32'hDEADBEEF, 4'b0111, 32'h00000000, 0, 8'h00);
    tbl[1]  = mk(0, 1, 32'h1000, 32'h0,        4'b0111, 32'hDEADBEEF, 0, 8'h00);
    tbl[2]  = mk(0, 1, 32'h1003, 32'h0,        4'b1001, 32'hFFFFFFDE, 0, 8'h00);
    tbl[3]  = mk(0, 1, 32'h1001, 32'h0,        4'b0001, 32'h000000BE, 0, 8'h00);
    tbl[4]  = mk(0, 1, 32'h1002, 32'h0,        4'b1011, 32'hFFFFDEAD, 0, 8'h00);
    tbl[5]  = mk(1, 0, 32'h1002, 32'h00000055, 4'b0001, 32'hFFFFDEAD, 0, 8'h00);
    tbl[6]  = mk(0, 1, 32'h1000, 32'h0,        4'b0111, 32'hDE55BEEF, 0, 8'h00);
    tbl[7]  = mk(1, 0, 32'h1000, 32'h00001234, 4'b0011, 32'hDE55BEEF, 0, 8'h00);
    tbl[8]  = mk(0, 1, 32'h1000, 32'h0,        4'b0111, 32'hDE551234, 0, 8'h00);
    tbl[9]  = mk(0, 1, 32'h1001, 32'h0,        4'b0011, 32'h00000000, 1, 8'h00);
    tbl[10] = mk(1, 0, 32'h0FFC, 32'hCAFEF00D, 4'b0111, 32'h00000000, 1, 8'h00);
    tbl[11] = mk(0, 1, 32'h1000, 32'h0,        4'b0111, 32'hDE551234, 0, 8'h00);
    tbl[12] = mk(1, 0, 32'h2000, 32'h000000A5, 4'b0111, 32'hDE551234, 0, 8'hA5);
    tbl[13] = mk(0, 1, 32'h2000, 32'h0,        4'b1001, 32'hFFFFFFA5, 0, 8'hA5);
    tbl[14] = mk(0, 1, 32'h2000, 32'h0,        4'b0011, 32'h000000A5, 0, 8'hA5);
    tbl[15] = mk(1, 1, 32'h2000, 32'h0000003C, 4'b0001, 32'h000000A5, 0, 8'h3C);
    tbl[16] = mk(0, 1, 32'h1000, 32'h0,        4'b0010, 32'h00000000, 1, 8'h3C);
    tbl[17] = mk(1, 0, 32'h1002, 32'hFFFFFFFF, 4'b0111, 32'h00000000, 1, 8'h3C);
    tbl[18] = mk(0, 1, 32'h1000, 32'h0,        4'b0111, 32'hDE551234, 0, 8'h3C);
    tbl[19] = mk(0, 1, 32'h2004, 32'h0,        4'b0111, 32'h00000000, 1, 8'h3C);
    tbl[20] = mk(1, 0, 32'h2000, 32'h0000BEEF, 4'b0011, 32'h00000000, 0, 8'hEF);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(clk_stall), 32'h0);
    chk("reset_read_data", read_data, 32'h0);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      access(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].sm, rdv, ev, sc);
      chk($sformatf("vec%0d_read_data", i), rdv, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(ev), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
      chk($sformatf("vec%0d_stall_cycles", i), 32'(sc), tbl[i].wr ? 32'(STORE_STALL) : 32'(LOAD_STALL));
    end

    // Reset clears the LED register and read_data
    do_reset();
    #1;
    chk("led_after_reset", 32'(led), 32'h0);
    chk("read_data_after_reset", read_data, 32'h0);

    // Reset while a store is committing drops the store
    access(1, 0, 32'h1004, 32'h77665544, 4'b0111, rdv, ev, sc);
    @(negedge clk);
    addr = 32'h1004; write_data = 32'h11111111; memwrite = 1'b1; memread = 1'b0; sign_mask = 4'b0111;
    @(posedge clk); #1;
    memwrite = 1'b0;
`ifndef DMEM_BYTE_ENABLE_STORE_EN
    @(posedge clk); #1;
`endif
    chk("commit_stall_before_reset", 32'(clk_stall), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("commit_reset_stall", 32'(clk_stall), 32'h0);
    chk("commit_reset_err", 32'(err), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1, 32'h1004, 32'h0, 4'b0111, rdv, ev, sc);
    chk("commit_reset_prior_value", rdv, 32'h77665544);
    chk("commit_reset_load_err", 32'(ev), 32'h0);

    // Randomized phase against the byte model
    m_led = 8'h00; m_rd = 32'h77665544; m_err = 1'b0;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      a = 32'h1000 + 32'(4 * w);
      model(1, 0, a, d, 4'b0111);
      access(1, 0, a, d, 4'b0111, rdv, ev, sc);
    end
    for (int t = 0; t < 200; t++) begin
      int r;
      r  = $urandom_range(0, 9);
      wr = 1'($urandom_range(0, 1));
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      sm = {1'($urandom_range(0, 1)), good_sz[$urandom_range(0, 2)]};
      d  = $urandom;
      if (r <= 6)      a = 32'h1000 + 32'($urandom_range(0, 63));
      else if (r == 7) a = 32'h2000;
      else if (r == 8) a = bad_a[$urandom_range(0, 2)];
      else begin
        a = 32'h1000 + 32'($urandom_range(0, 63));
        sm[2:0] = bad_sz[$urandom_range(0, 4)];
      end
      model(wr, rd, a, d, sm);
      access(wr, rd, a, d, sm, rdv, ev, sc);
      chk($sformatf("rand%0d_read_data", t), rdv, m_rd);
      chk($sformatf("rand%0d_err", t), 32'(ev), 32'(m_err));
      chk($sformatf("rand%0d_led", t), 32'(led), 32'(m_led));
      chk($sformatf("rand%0d_stall_cycles", t), 32'(sc), wr ? 32'(STORE_STALL) : 32'(LOAD_STALL));
    end

    // Final reset state
    do_reset();
    #1;
    chk("final_reset_led", 32'(led), 32'h0);
    chk("final_reset_stall", 32'(clk_stall), 32'h0);
    chk("final_reset_read_data", read_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
